// File: rtl/skolem_lshr_slt_search_pkg.sv
// Shared types and helpers for the (s >> x) <s t witness search.
// Holds the FSM state type, the result-width helper and the closed-form invertibility condition.
package skolem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int xw_f(input int w);
    return $clog2(w + 1);
  endfunction

  // The condition holds iff x=0 works (s <s t) or the all-zero shift result works (0 <s t).
  function automatic logic ic_lshr_slt(input logic [63:0] s, input logic [63:0] t, input int w);
    logic [63:0] mask;
    logic [63:0] sm;
    logic [63:0] tm;
    logic        ss;
    logic        ts;
    logic        s_lt_t;
    logic        t_pos;
    mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sm     = s & mask;
    tm     = t & mask;
    ss     = sm[6'(w - 1)];
    ts     = tm[6'(w - 1)];
    s_lt_t = (ss != ts) ? ss : (sm < tm);
    t_pos  = !ts && (tm != 64'd0);
    return s_lt_t | t_pos;
  endfunction

endpackage

// File: rtl/skolem_lshr_slt_search_cell.sv
// Shared shift + signed-compare datapath: hit = signed(s >> cand) < signed(t).
// Purely combinational; a shift amount of W or more yields zero.
module lshr_slt_cell #(
  parameter int W  = 8,
  parameter int XW = 4
) (
  input  logic [W-1:0]  i_s,
  input  logic [W-1:0]  i_t,
  input  logic [XW-1:0] i_cand,
  output logic          o_hit
);

  logic [W-1:0] w_shift;

  assign w_shift = i_s >> i_cand;
  assign o_hit   = $signed(w_shift) < $signed(i_t);

endmodule

// File: rtl/skolem_lshr_slt_search.sv
// Sequential witness search for (s >> x) <s t over x = 0..W, one candidate per cycle.
// Optional closed-form early abort and cross-check enabled by SKOLEM_IC_CHECK_EN.
module skolem_lshr_slt_search
  import skolem_pkg::*;
#(
  parameter int W  = 8,
  parameter int XW = xw_f(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [W-1:0]  req_s,
  input  logic [W-1:0]  req_t,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_found,
  output logic [XW-1:0] resp_x,
  output logic          resp_ic_mismatch,
  output logic          busy
);

  localparam logic [XW-1:0] W_X = XW'(W);

  state_e        r_state;
  logic [W-1:0]  r_s;
  logic [W-1:0]  r_t;
  logic [XW-1:0] r_cand;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic          r_found;
  logic [XW-1:0] r_x;
  logic          r_busy;
  logic          w_hit;

  lshr_slt_cell #(
    .W  (W),
    .XW (XW)
  ) u_cell (
    .i_s    (r_s),
    .i_t    (r_t),
    .i_cand (r_cand),
    .o_hit  (w_hit)
  );

`ifdef SKOLEM_IC_CHECK_EN
  logic r_ic;
  logic r_mismatch;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_s          <= '0;
      r_t          <= '0;
      r_cand       <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_found      <= 1'b0;
      r_x          <= '0;
      r_busy       <= 1'b0;
`ifdef SKOLEM_IC_CHECK_EN
      r_ic         <= 1'b0;
      r_mismatch   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_s         <= req_s;
            r_t         <= req_t;
            r_cand      <= '0;
            r_state     <= SEARCH;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
`ifdef SKOLEM_IC_CHECK_EN
            r_ic        <= ic_lshr_slt(64'(req_s), 64'(req_t), W);
`endif
          end
        end
        SEARCH: begin
`ifdef SKOLEM_IC_CHECK_EN
          // No witness can exist: report "not found" after a single cycle.
          if (!r_ic) begin
            r_found      <= 1'b0;
            r_x          <= W_X;
            r_mismatch   <= 1'b0;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
          end else
`endif
          if (w_hit) begin
            r_found      <= 1'b1;
            r_x          <= r_cand;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
`ifdef SKOLEM_IC_CHECK_EN
            r_mismatch   <= !r_ic;
`endif
          end else if (r_cand == W_X) begin
            r_found      <= 1'b0;
            r_x          <= W_X;
            r_resp_valid <= 1'b1;
            r_state      <= DONE;
`ifdef SKOLEM_IC_CHECK_EN
            r_mismatch   <= r_ic;
`endif
          end else begin
            r_cand <= r_cand + 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_found = r_found;
  assign resp_x     = r_x;
  assign busy       = r_busy;

`ifdef SKOLEM_IC_CHECK_EN
  assign resp_ic_mismatch = r_mismatch;
`else
  assign resp_ic_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_skolem_lshr_slt_search.sv
// Randomized + directed bench for skolem_lshr_slt_search (W=8) against a behavioural model.
// Build with +define+SKOLEM_IC_CHECK_EN to exercise the early-abort variant.
module tb_skolem_lshr_slt_search;
  import skolem_pkg::*;

  localparam int W  = 8;
  localparam int XW = 4;
`ifdef SKOLEM_IC_CHECK_EN
  localparam int NF_LAT = 1;
`else
  localparam int NF_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [W-1:0]  req_s = '0;
  logic [W-1:0]  req_t = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_found;
  logic [XW-1:0] resp_x;
  logic          resp_ic_mismatch;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  skolem_lshr_slt_search #(.W(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_s            (req_s),
    .req_t            (req_t),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_found       (resp_found),
    .resp_x           (resp_x),
    .resp_ic_mismatch (resp_ic_mismatch),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: first x in 0..W with (s / 2^x) < t as signed integers; x=0 keeps s's sign.
  function automatic void ref_search(input logic [7:0] s, input logic [7:0] t,
                                     output logic found, output int x);
    int tv;
    int sv;
    tv = t[7] ? int'(t) - 256 : int'(t);
    found = 1'b0;
    x = W;
    for (int k = 0; k <= W; k++) begin
      if (k == 0) sv = s[7] ? int'(s) - 256 : int'(s);
      else        sv = int'(s) / (1 << k);
      if (sv < tv) begin
        found = 1'b1;
        x = k;
        break;
      end
    end
  endfunction

  // Model: 0 idle, 1 searching, 2 result held.
  int   m_phase = 0;
  int   m_cnt = 0;
  logic m_found = 1'b0;
  int   m_x = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_cnt = 0;
    end else begin
      case (m_phase)
        0: if (req_valid) begin
          ref_search(req_s, req_t, m_found, m_x);
          m_cnt = m_found ? m_x + 1 : NF_LAT;
          m_phase = 1;
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: if (resp_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", int'(req_ready), int'(m_phase == 0));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("resp_valid", int'(resp_valid), int'(m_phase == 2));
    chk("ic_mismatch", int'(resp_ic_mismatch), 0);
    if (m_phase == 2) begin
      chk("resp_found", int'(resp_found), int'(m_found));
      chk("resp_x", int'(resp_x), m_x);
    end
  end

  task automatic do_req(input logic [7:0] s, input logic [7:0] t, input int hold,
                        input int exp_lat, input int exp_found, input int exp_x);
    int lat;
    for (int i = 0; i < 30 && !req_ready; i++) begin
      @(posedge clk); #1;
    end
    if (!req_ready) begin
      miscompares++;
      $display("FAIL ready_timeout: req_ready stayed 0 (t=%0t)", $time);
    end
    req_valid = 1'b1; req_s = s; req_t = t; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_s = 8'($urandom); req_t = 8'($urandom);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      resp_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    resp_ready = 1'b0;
    if (!resp_valid) begin
      miscompares++;
      $display("FAIL resp_timeout: resp_valid stayed 0 for %0d cycles (t=%0t)", lat, $time);
    end
    if (exp_lat >= 0) begin
      chk("lit_latency", lat, exp_lat);
      chk("lit_found", int'(resp_found), exp_found);
      chk("lit_x", int'(resp_x), exp_x);
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom); req_s = 8'($urandom); req_t = 8'($urandom);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_found", int'(resp_found), 0);
    chk("rst_resp_x", int'(resp_x), 0);
    chk("rst_busy", int'(busy), 0);
    chk("pkg_ic_7f_10", int'(ic_lshr_slt(64'h7F, 64'h10, 8)), 1);
    chk("pkg_ic_05_00", int'(ic_lshr_slt(64'h05, 64'h00, 8)), 0);
    chk("pkg_ic_ff_ff", int'(ic_lshr_slt(64'hFF, 64'hFF, 8)), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    do_req(8'h80, 8'h00, 0, 1, 1, 0);
    do_req(8'h7F, 8'h10, 0, 4, 1, 3);
    do_req(8'h05, 8'h00, 0, NF_LAT, 0, 8);
    do_req(8'hFF, 8'hFF, 0, NF_LAT, 0, 8);
    do_req(8'h7F, 8'h10, 5, 4, 1, 3);
    do_req(8'h80, 8'h00, 0, 1, 1, 0);

    // Reset while the search sits at candidate 2.
    req_valid = 1'b1; req_s = 8'h7F; req_t = 8'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", int'(req_ready), 1);
    chk("mid_rst_resp_valid", int'(resp_valid), 0);
    chk("mid_rst_resp_found", int'(resp_found), 0);
    chk("mid_rst_resp_x", int'(resp_x), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    do_req(8'h7F, 8'h10, 0, 4, 1, 3);

    for (int n = 0; n < 300; n++) begin
      logic [7:0] rs;
      logic [7:0] rt;
      rs = 8'($urandom);
      rt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      do_req(rs, rt, $urandom_range(0, 3), -1, 0, 0);
    end

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
